// File: rtl/pc_sequencer.sv
// Hack PC sequencer: fetch / execute / PC update control FSM.
// Drives PC strobes, detects self-loop halt and fetch timeouts.
module pc_sequencer #(
    parameter int unsigned FETCH_TIMEOUT     = 15,
    parameter bit          HALT_ON_SELF_LOOP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_en,
    input  logic [15:0] pc_value,
    output logic        fetch_req,
    input  logic        instr_ack,
    input  logic        exec_done,
    input  logic [2:0]  jump,
    input  logic        zr,
    input  logic        ng,
    input  logic [15:0] jump_target,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        pc_reset,
    output logic        halted,
    output logic        fetch_err,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_e;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [15:0] retired_q, retired_d;
    logic [2:0]  jump_q, jump_d;
    logic        zr_q, zr_d;
    logic        ng_q, ng_d;
    logic [15:0] tgt_q, tgt_d;

    logic taken;
    logic self_loop;
    logic tmo_last;

    // Jump condition and halt detection from the captured bundle.
    always_comb begin
        taken = (jump_q[2] & ng_q)
              | (jump_q[1] & zr_q)
              | (jump_q[0] & ~zr_q & ~ng_q);
        self_loop = HALT_ON_SELF_LOOP
                  && taken
                  && (tgt_q == pc_value);
        tmo_last = (tmo_q == TMO_LAST);
    end

    // State, counters and capture registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tmo_q     <= 8'd0;
            err_q     <= 1'b0;
            retired_q <= 16'd0;
            jump_q    <= 3'd0;
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
            tgt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            jump_q    <= jump_d;
            zr_q      <= zr_d;
            ng_q      <= ng_d;
            tgt_q     <= tgt_d;
        end
    end

    // Next-state and datapath-register logic.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        retired_d = retired_q;
        jump_d    = jump_q;
        zr_d      = zr_q;
        ng_d      = ng_q;
        tgt_d     = tgt_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_en) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                tmo_d = 8'd0;
                if (instr_ack) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (instr_ack) begin
                    state_d = S_EXEC;
                end else if (tmo_last) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    jump_d  = jump;
                    zr_d    = zr;
                    ng_d    = ng;
                    tgt_d   = jump_target;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                retired_d = retired_q + 16'd1;
                if (self_loop) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs; pc_reset also follows the raw reset input.
    always_comb begin
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            S_FETCH, S_WAIT: fetch_req = 1'b1;
            S_UPDATE: begin
                pc_load = taken;
                pc_inc  = ~taken;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
        pc_reset  = ~reset | (state_q == S_IDLE);
        fetch_err = err_q;
        retired   = retired_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register.
// Each task drives one scenario and checks its own results.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_en;
    logic [15:0] pc_value;
    logic        fetch_req;
    logic        instr_ack;
    logic        exec_done;
    logic [2:0]  jump;
    logic        zr;
    logic        ng;
    logic [15:0] jump_target;
    logic        pc_load;
    logic        pc_inc;
    logic        pc_reset;
    logic        halted;
    logic        fetch_err;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .FETCH_TIMEOUT(15),
        .HALT_ON_SELF_LOOP(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run_en(run_en),
        .pc_value(pc_value),
        .fetch_req(fetch_req),
        .instr_ack(instr_ack),
        .exec_done(exec_done),
        .jump(jump),
        .zr(zr),
        .ng(ng),
        .jump_target(jump_target),
        .pc_load(pc_load),
        .pc_inc(pc_inc),
        .pc_reset(pc_reset),
        .halted(halted),
        .fetch_err(fetch_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // PC register model: reset has priority over load and increment.
    always @(posedge clk) begin
        if (pc_reset) pc_value <= 16'h0000;
        else if (pc_load) pc_value <= jump_target;
        else if (pc_inc) pc_value <= pc_value + 16'h0001;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles, then release with the given run_en.
    task automatic do_reset(input logic start);
        reset = 1'b0;
        run_en = start;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // One instruction from FETCH through UPDATE; samples the strobes.
    task automatic run_one(input logic [2:0] j, input logic z, input logic n,
                           input logic [15:0] t, output logic ld, output logic inc);
        instr_ack = 1'b1;
        exec_done = 1'b0;
        tick();
        tick();
        jump = j;
        zr = z;
        ng = n;
        jump_target = t;
        exec_done = 1'b1;
        tick();
        ld = pc_load;
        inc = pc_inc;
        exec_done = 1'b0;
        jump = 3'b000;
        zr = 1'b0;
        ng = 1'b0;
    endtask

    task automatic test_reset();
        instr_ack = 1'b0;
        exec_done = 1'b0;
        do_reset(1'b1);
        checks++;
        if (pc_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_pc_reset: got %b expected 1", pc_reset);
        end
        checks++;
        if ({fetch_req, pc_load, pc_inc, halted, fetch_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {fetch_req, pc_load, pc_inc, halted, fetch_err});
        end
        tick();
        checks++;
        if (fetch_req !== 1'b1 || pc_reset !== 1'b0) begin
            errors++;
            $display("FAIL start_fetch: got req=%b rst=%b expected req=1 rst=0",
                     fetch_req, pc_reset);
        end
        checks++;
        if (pc_value !== 16'h0 || retired !== 16'h0) begin
            errors++;
            $display("FAIL start_pc_ret: got pc=%h ret=%h expected 0 0",
                     pc_value, retired);
        end
        tick();
        checks++;
        if (fetch_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_req: got %b expected 1", fetch_req);
        end
    endtask

    task automatic test_sequential();
        int n_inc = 0;
        int n_load = 0;
        int last = 0;
        int bad_gap = 0;
        do_reset(1'b0);
        instr_ack = 1'b1;
        exec_done = 1'b1;
        jump = 3'b000;
        tick();
        run_en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (pc_load) n_load++;
            if (pc_inc) begin
                n_inc++;
                if (c - last != 3) bad_gap++;
                last = c;
            end
        end
        run_en = 1'b0;
        tick();
        checks++;
        if (n_inc !== 4) begin
            errors++;
            $display("FAIL seq_inc_count: got %0d expected 4", n_inc);
        end
        checks++;
        if (n_load !== 0) begin
            errors++;
            $display("FAIL seq_no_load: got %0d expected 0", n_load);
        end
        checks++;
        if (bad_gap !== 0) begin
            errors++;
            $display("FAIL seq_spacing: got %0d bad gaps expected 0", bad_gap);
        end
        checks++;
        if (pc_value !== 16'd4 || retired !== 16'd4) begin
            errors++;
            $display("FAIL seq_pc_ret: got pc=%h ret=%h expected 4 4",
                     pc_value, retired);
        end
        exec_done = 1'b0;
    endtask

    task automatic test_jump_conditions();
        logic [2:0] jv [6] = '{3'b001, 3'b001, 3'b100, 3'b010, 3'b000, 3'b111};
        logic       zv [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       nv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       tk [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic ld, inc;
        logic [15:0] exp_pc;
        for (int i = 0; i < 6; i++) begin
            do_reset(1'b1);
            run_one(jv[i], zv[i], nv[i], 16'h0040, ld, inc);
            checks++;
            if (ld !== tk[i] || inc !== ~tk[i]) begin
                errors++;
                $display("FAIL jump_%0d j=%b zr=%b ng=%b: got ld=%b inc=%b expected ld=%b",
                         i, jv[i], zv[i], nv[i], ld, inc, tk[i]);
            end
            tick();
            exp_pc = tk[i] ? 16'h0040 : 16'h0001;
            checks++;
            if (pc_value !== exp_pc) begin
                errors++;
                $display("FAIL jump_pc_%0d: got %h expected %h", i, pc_value, exp_pc);
            end
        end
    endtask

    task automatic test_self_loop();
        logic ld, inc;
        int activity = 0;
        do_reset(1'b1);
        run_one(3'b111, 1'b0, 1'b0, 16'h0010, ld, inc);
        run_one(3'b111, 1'b0, 1'b0, 16'h0010, ld, inc);
        checks++;
        if (ld !== 1'b1 || inc !== 1'b0) begin
            errors++;
            $display("FAIL loop_load: got ld=%b inc=%b expected ld=1 inc=0", ld, inc);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || pc_value !== 16'h0010) begin
            errors++;
            $display("FAIL loop_halt: got halted=%b pc=%h expected 1 0010",
                     halted, pc_value);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (fetch_req || pc_load || pc_inc || !halted) activity++;
        end
        checks++;
        if (activity !== 0) begin
            errors++;
            $display("FAIL loop_quiet: got %0d active cycles expected 0", activity);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b0 || pc_reset !== 1'b1) begin
            errors++;
            $display("FAIL loop_reset: got halted=%b rst=%b expected 0 1",
                     halted, pc_reset);
        end
        reset = 1'b1;
    endtask

    task automatic test_timeout();
        int early = 0;
        instr_ack = 1'b0;
        exec_done = 1'b0;
        do_reset(1'b1);
        tick();
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (halted || !fetch_req || fetch_err) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL tmo_early: got %0d bad WAIT cycles expected 0", early);
        end
        tick();
        checks++;
        if (fetch_err !== 1'b1 || halted !== 1'b1 || fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err: got err=%b halted=%b req=%b expected 1 1 0",
                     fetch_err, halted, fetch_req);
        end
        do_reset(1'b1);
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err_clear: got %b expected 0", fetch_err);
        end
        tick();
        for (int c = 1; c <= 15; c++) tick();
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        checks++;
        if (fetch_err !== 1'b0 || halted !== 1'b0 || fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL tmo_late_ack: got err=%b halted=%b req=%b expected 0 0 0",
                     fetch_err, halted, fetch_req);
        end
    endtask

    task automatic test_reset_wait_and_wrap();
        instr_ack = 1'b0;
        exec_done = 1'b0;
        do_reset(1'b1);
        tick();
        tick();
        tick();
        checks++;
        if (fetch_req !== 1'b1) begin
            errors++;
            $display("FAIL midwait_req: got %b expected 1", fetch_req);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (fetch_req !== 1'b0 || pc_reset !== 1'b1) begin
            errors++;
            $display("FAIL midwait_reset: got req=%b rst=%b expected 0 1",
                     fetch_req, pc_reset);
        end
        reset = 1'b1;
        run_en = 1'b0;
        tick();
        tick();
        checks++;
        if (fetch_req !== 1'b0 || pc_reset !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: got req=%b rst=%b expected 0 1",
                     fetch_req, pc_reset);
        end
        force dut.retired_q = 16'hFFFF;
        tick();
        release dut.retired_q;
        tick();
        checks++;
        if (retired !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h expected ffff", retired);
        end
        instr_ack = 1'b1;
        exec_done = 1'b1;
        jump = 3'b000;
        run_en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (retired !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: got %h expected 0000", retired);
        end
        exec_done = 1'b0;
        instr_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        run_en = 1'b0;
        instr_ack = 1'b0;
        exec_done = 1'b0;
        jump = 3'b000;
        zr = 1'b0;
        ng = 1'b0;
        jump_target = 16'h0000;
        pc_value = 16'h0000;
        test_reset();
        test_sequential();
        test_jump_conditions();
        test_self_loop();
        test_timeout();
        test_reset_wait_and_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
